// File: rtl/line_dma_pkg.sv
// line_dma_pkg
//   Shared definitions for the line DMA sequencer slice:
//     state_t        - sequencer FSM states
//     DEF_BURST_LEN  - default words per Avalon-MM write burst
//     DEF_LINE_WORDS - default 32-bit words per scan line
//     WORD_BYTES     - byte stride of one 32-bit word
`timescale 1ns/1ps
package line_dma_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_DATA = 2'd1,
      BURST     = 2'd2,
      LINE_END  = 2'd3
   } state_t;

   localparam int DEF_BURST_LEN  = 16;
   localparam int DEF_LINE_WORDS = 512;
   localparam int WORD_BYTES     = 4;

endpackage

// File: rtl/line_dma_addr_gen.sv
// line_dma_addr_gen
//   Ring-buffer address generator: owns the latched base / line count and the
//   line and burst counters, and produces the byte address of the current burst.
//   Ports:
//     clk, reset_n      - clock, asynchronous active-low reset
//     i_start           - latch i_base / i_nlines and clear both counters
//     i_base, i_nlines  - ring configuration sampled on i_start
//     i_burst_done      - current burst finished, advance burst counter
//     i_line_adv        - current line finished, advance line counter
//     o_addr            - base + (line*LINE_WORDS + burst*BURST_LEN)*4, mod 2^32
//     o_last_burst      - burst counter is on the final burst of the line
//     o_line_start      - burst counter is 0 (at a line boundary)
//     o_line            - current line index
`timescale 1ns/1ps
module line_dma_addr_gen
   import line_dma_pkg::*;
#(
   parameter int BURST_LEN  = DEF_BURST_LEN,
   parameter int LINE_WORDS = DEF_LINE_WORDS
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        i_start,
   input  logic [31:0] i_base,
   input  logic [15:0] i_nlines,
   input  logic        i_burst_done,
   input  logic        i_line_adv,
   output logic [31:0] o_addr,
   output logic        o_last_burst,
   output logic        o_line_start,
   output logic [15:0] o_line
);

   localparam int BPL = LINE_WORDS / BURST_LEN;
   localparam int BW  = (BPL > 1) ? $clog2(BPL) : 1;
   localparam logic [BW-1:0] LAST_BURST = BW'(BPL - 1);

   logic [31:0]   r_base;
   logic [15:0]   r_nlines;
   logic [15:0]   r_line;
   logic [BW-1:0] r_burst;
   logic [31:0]   w_word_off;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_base   <= '0;
         r_nlines <= '0;
         r_line   <= '0;
         r_burst  <= '0;
      end else if (i_start) begin
         r_base   <= i_base;
         // A zero-length ring behaves as a single line rewritten in place
         r_nlines <= (i_nlines == 16'd0) ? 16'd1 : i_nlines;
         r_line   <= '0;
         r_burst  <= '0;
      end else begin
         if (i_burst_done)
            r_burst <= (r_burst == LAST_BURST) ? '0 : r_burst + 1'b1;
         if (i_line_adv)
            r_line <= (r_line == r_nlines - 16'd1) ? '0 : r_line + 16'd1;
      end
   end

   // 32-bit arithmetic throughout, so the ring wraps modulo 2^32
   assign w_word_off   = 32'(r_line) * 32'(LINE_WORDS) + 32'(r_burst) * 32'(BURST_LEN);
   assign o_addr       = r_base + w_word_off * 32'(WORD_BYTES);
   assign o_last_burst = (r_burst == LAST_BURST);
   assign o_line_start = (r_burst == '0);
   assign o_line       = r_line;

endmodule

// File: rtl/line_dma_sequencer.sv
// line_dma_sequencer
//   Moves scan-line pixel words from an upstream FIFO into a ring of line
//   buffers in memory using fixed-length Avalon-MM write bursts.
//   Ports:
//     clk, reset_n                  - clock, asynchronous active-low reset
//     cfg_base, cfg_nlines          - ring base byte address / line count (latched on start)
//     cfg_enable                    - level run request
//     in_data, in_valid, in_ready   - upstream word stream
//     in_level                      - upstream FIFO fill in words
//     m_address .. m_waitrequest    - Avalon-MM burst write master
//     busy                          - not IDLE
//     line_done, line_idx           - one-cycle pulse with index of the completed line
`timescale 1ns/1ps
module line_dma_sequencer
   import line_dma_pkg::*;
#(
   parameter int BURST_LEN  = DEF_BURST_LEN,
   parameter int LINE_WORDS = DEF_LINE_WORDS
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] cfg_base,
   input  logic [15:0] cfg_nlines,
   input  logic        cfg_enable,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_level,
   output logic [31:0] m_address,
   output logic        m_write,
   output logic [31:0] m_writedata,
   output logic [6:0]  m_burstcount,
   input  logic        m_waitrequest,
   output logic        busy,
   output logic        line_done,
   output logic [15:0] line_idx
);

   localparam int WW = $clog2(BURST_LEN);
   localparam logic [WW-1:0] LAST_WORD = WW'(BURST_LEN - 1);

   state_t        r_state;
   logic [WW-1:0] r_word;
   logic [31:0]   r_m_address;
   logic [6:0]    r_m_burstcount;
   logic          r_line_done;
   logic [15:0]   r_line_idx;

   logic          w_in_burst;
   logic          w_xfer;
   logic          w_burst_end;
   logic          w_start;
   logic          w_line_adv;
   logic          w_level_ok;
   logic [31:0]   w_addr;
   logic          w_last_burst;
   logic          w_line_start;
   logic [15:0]   w_line;

   assign w_in_burst  = (r_state == BURST);
   assign w_xfer      = m_write & ~m_waitrequest;
   assign w_burst_end = w_in_burst & w_xfer & (r_word == LAST_WORD);
   assign w_start     = (r_state == IDLE) & cfg_enable;
   assign w_line_adv  = (r_state == LINE_END);
   assign w_level_ok  = (in_level >= 16'(BURST_LEN));

   line_dma_addr_gen #(
      .BURST_LEN  (BURST_LEN),
      .LINE_WORDS (LINE_WORDS)
   ) u_addr_gen (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_start      (w_start),
      .i_base       (cfg_base),
      .i_nlines     (cfg_nlines),
      .i_burst_done (w_burst_end),
      .i_line_adv   (w_line_adv),
      .o_addr       (w_addr),
      .o_last_burst (w_last_burst),
      .o_line_start (w_line_start),
      .o_line       (w_line)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= IDLE;
         r_word         <= '0;
         r_m_address    <= '0;
         r_m_burstcount <= '0;
         r_line_done    <= 1'b0;
         r_line_idx     <= '0;
      end else begin
         r_line_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (cfg_enable) r_state <= WAIT_DATA;
            end
            WAIT_DATA: begin
               // Stopping is only allowed on a line boundary; mid-line we keep going
               if (!cfg_enable && w_line_start) begin
                  r_state <= IDLE;
               end else if (w_level_ok) begin
                  r_state        <= BURST;
                  r_m_address    <= w_addr;
                  r_m_burstcount <= 7'(BURST_LEN);
                  r_word         <= '0;
               end
            end
            BURST: begin
               if (w_xfer) begin
                  r_word <= r_word + 1'b1;
                  if (r_word == LAST_WORD) begin
                     if (w_last_burst) begin
                        r_state     <= LINE_END;
                        r_line_done <= 1'b1;
                        r_line_idx  <= w_line;
                     end else begin
                        r_state <= WAIT_DATA;
                     end
                  end
               end
            end
            LINE_END: begin
               r_state <= cfg_enable ? WAIT_DATA : IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Write side passes the FIFO head straight through while bursting
   assign m_write      = w_in_burst & in_valid;
   assign m_writedata  = w_in_burst ? in_data : '0;
   assign in_ready     = m_write & ~m_waitrequest;
   assign m_address    = r_m_address;
   assign m_burstcount = r_m_burstcount;
   assign busy         = (r_state != IDLE);
   assign line_done    = r_line_done;
   assign line_idx     = r_line_idx;

endmodule

// File: tb/tb_line_dma_sequencer.sv
`timescale 1ns/1ps
module tb_line_dma_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] cfg_base;
   logic [15:0] cfg_nlines;
   logic        cfg_enable;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_level;
   logic [31:0] m_address;
   logic        m_write;
   logic [31:0] m_writedata;
   logic [6:0]  m_burstcount;
   logic        m_waitrequest;
   logic        busy;
   logic        line_done;
   logic [15:0] line_idx;

   line_dma_sequencer #(.BURST_LEN(16), .LINE_WORDS(512)) dut (
      .clk(clk), .reset_n(reset_n), .cfg_base(cfg_base), .cfg_nlines(cfg_nlines),
      .cfg_enable(cfg_enable), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .in_level(in_level), .m_address(m_address), .m_write(m_write),
      .m_writedata(m_writedata), .m_burstcount(m_burstcount),
      .m_waitrequest(m_waitrequest), .busy(busy), .line_done(line_done), .line_idx(line_idx)
   );

   always #5 clk = ~clk;

   typedef struct { logic [15:0] idx; int nb; } ld_t;

   logic [31:0] aq[$];   // expected burst start addresses
   logic [31:0] dq[$];   // expected write data, in order
   ld_t         lq[$];   // expected line_done events

   int checks = 0;
   int errors = 0;
   int src_idx = 0;      // owned by source
   int exp_next = 0;     // owned by main
   int exp_bursts = 0;   // owned by main
   bit acc = 0;          // owned by monitor
   bit mon_en = 0;
   bit wr_rand = 0;
   int mon_word = 0;
   int mon_bursts = 0;
   bit ld_expect = 0;
   logic [31:0] cur_addr = '0;

   function automatic logic [31:0] word_of(input int n);
      logic [15:0] lo;
      lo = n[15:0];
      return {lo ^ 16'hC3A5, lo};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic fail1(input string nm, input logic [31:0] act);
      checks++;
      errors++;
      $display("FAIL %s: got %h, nothing expected", nm, act);
   endtask

   // One full line of expectations: 32 bursts of 16 words, then line_done
   task automatic push_line(input logic [31:0] base, input int line);
      for (int k = 0; k < 32; k++)
         aq.push_back(base + 32'(line) * 32'h800 + 32'(k) * 32'h40);
      for (int w = 0; w < 512; w++) begin
         dq.push_back(word_of(exp_next));
         exp_next++;
      end
      exp_bursts += 32;
      lq.push_back('{idx: 16'(line), nb: exp_bursts});
   endtask

   task automatic set_en(input logic v);
      @(posedge clk); #1 cfg_enable = v;
   endtask

   task automatic new_phase();
      @(posedge clk); #1 mon_en = 0;
      @(posedge clk); #1 mon_en = 1;
      exp_bursts = 0;
   endtask

   task automatic wait_bursts(input int n, input string nm);
      int c = 0;
      while (mon_bursts < n && c < 5000) begin @(posedge clk); c++; end
      if (c >= 5000) fail1({nm, "_timeout"}, 32'(mon_bursts));
   endtask

   task automatic wait_done(input string nm);
      int c = 0;
      while ((busy || aq.size() != 0 || lq.size() != 0) && c < 4000) begin
         @(posedge clk); c++;
      end
      if (c >= 4000) fail1({nm, "_timeout"}, 32'(c));
      @(negedge clk);
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_bursts_left"}, aq.size(), 0);
      chk({nm, "_lines_left"}, lq.size(), 0);
      chk({nm, "_words_left"}, dq.size(), 0);
   endtask

   // Source: presents word_of(src_idx), advancing after each accepted word
   initial begin
      in_data = word_of(0);
      m_waitrequest = 1'b0;
      forever begin
         @(posedge clk);
         if (acc) src_idx++;
         #1;
         in_data = word_of(src_idx);
         m_waitrequest = wr_rand ? 1'($urandom_range(0, 1)) : 1'b0;
      end
   end

   // Monitor: pops and compares whenever the DUT writes or pulses line_done
   initial begin
      ld_t e;
      logic [31:0] a;
      forever begin
         @(negedge clk);
         acc = m_write & ~m_waitrequest;
         if (!mon_en) begin
            mon_word = 0; mon_bursts = 0; ld_expect = 0;
         end else begin
            chk("line_done_timing", line_done, ld_expect);
            if (line_done) begin
               if (lq.size() == 0) fail1("line_done_unexpected", line_idx);
               else begin
                  e = lq.pop_front();
                  chk("line_idx", line_idx, e.idx);
                  chk("line_done_burst_cnt", mon_bursts, e.nb);
               end
            end
            ld_expect = 0;
            if (m_write && mon_word != 0) begin
               chk("addr_hold", m_address, cur_addr);
               chk("burstcount_hold", m_burstcount, 16);
            end
            if (acc) begin
               chk("in_ready", in_ready, 1);
               if (mon_word == 0) begin
                  mon_bursts++;
                  if (aq.size() == 0) fail1("burst_unexpected", m_address);
                  else begin
                     a = aq.pop_front();
                     cur_addr = a;
                     chk("burst_addr", m_address, a);
                     chk("burstcount", m_burstcount, 16);
                  end
               end
               if (dq.size() == 0) fail1("word_unexpected", m_writedata);
               else chk("writedata", m_writedata, dq.pop_front());
               mon_word = (mon_word == 15) ? 0 : mon_word + 1;
               if (mon_word == 0 && mon_bursts % 32 == 0) ld_expect = 1;
            end
         end
      end
   end

   initial begin
      reset_n = 1'b0; cfg_base = 32'h0; cfg_nlines = 16'd0; cfg_enable = 1'b0;
      in_valid = 1'b1; in_level = 16'd64;
      #3;
      chk("rst_m_write", m_write, 0);
      chk("rst_m_address", m_address, 0);
      chk("rst_m_burstcount", m_burstcount, 0);
      chk("rst_m_writedata", m_writedata, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_line_done", line_done, 0);
      chk("rst_line_idx", line_idx, 0);
      #19 reset_n = 1'b1;
      @(negedge clk);
      chk("idle_busy", busy, 0);

      // 1: two-line ring, FIFO full, third line wraps back to base
      new_phase();
      cfg_base = 32'h2000_0000; cfg_nlines = 16'd2;
      push_line(32'h2000_0000, 0);
      push_line(32'h2000_0000, 1);
      push_line(32'h2000_0000, 0);
      set_en(1);
      wait_bursts(67, "s1");
      set_en(0);
      wait_done("s1");

      // 2: random waitrequest, data in order, address held
      new_phase();
      wr_rand = 1;
      cfg_base = 32'h1000_0000; cfg_nlines = 16'd4;
      push_line(32'h1000_0000, 0);
      set_en(1);
      wait_bursts(2, "s2");
      set_en(0);
      wait_done("s2");
      wr_rand = 0;

      // 3: level threshold, m_write one cycle after in_level reaches 16
      new_phase();
      in_level = 16'd15;
      cfg_base = 32'h3000_0000; cfg_nlines = 16'd1;
      push_line(32'h3000_0000, 0);
      set_en(1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("lvl15_no_write", m_write, 0);
      end
      chk("lvl15_busy", busy, 1);
      @(posedge clk); #1 in_level = 16'd16;
      @(negedge clk); chk("lvl16_same_cycle", m_write, 0);
      @(negedge clk); chk("lvl16_next_cycle", m_write, 1);
      set_en(0);
      wait_done("s3");

      // 4: enable dropped during burst 3 of line 0
      new_phase();
      in_level = 16'd64;
      cfg_base = 32'h0800_0000; cfg_nlines = 16'd5;
      push_line(32'h0800_0000, 0);
      set_en(1);
      wait_bursts(3, "s4");
      set_en(0);
      wait_done("s4");

      // 5: base/nlines changes ignored while running; nlines=0 rewrites base
      new_phase();
      cfg_base = 32'h4000_0000; cfg_nlines = 16'd0;
      push_line(32'h4000_0000, 0);
      push_line(32'h4000_0000, 0);
      set_en(1);
      wait_bursts(5, "s5a");
      @(posedge clk); #1 cfg_base = 32'h5000_0000; cfg_nlines = 16'd3;
      wait_bursts(35, "s5b");
      set_en(0);
      wait_done("s5a");
      new_phase();
      push_line(32'h5000_0000, 0);
      set_en(1);
      wait_bursts(2, "s5c");
      set_en(0);
      wait_done("s5b");

      // 6: reset mid-burst, then restart from line 0 burst 0
      new_phase();
      cfg_base = 32'h6000_0000; cfg_nlines = 16'd4;
      push_line(32'h6000_0000, 0);
      push_line(32'h6000_0000, 1);
      aq.push_back(32'h6000_1000);
      for (int w = 0; w < 16; w++) begin dq.push_back(word_of(exp_next)); exp_next++; end
      set_en(1);
      wait_bursts(65, "s6");
      repeat (3) @(posedge clk);
      #1 chk("pre_rst_line_idx", line_idx, 1);
      #1 mon_en = 0; reset_n = 1'b0;
      #1;
      chk("arst_m_write", m_write, 0);
      chk("arst_m_address", m_address, 0);
      chk("arst_m_burstcount", m_burstcount, 0);
      chk("arst_m_writedata", m_writedata, 0);
      chk("arst_in_ready", in_ready, 0);
      chk("arst_busy", busy, 0);
      chk("arst_line_done", line_done, 0);
      chk("arst_line_idx", line_idx, 0);
      chk("arst_lines_seen", lq.size(), 0);
      cfg_enable = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      aq.delete(); dq.delete(); lq.delete();
      exp_next = src_idx;
      exp_bursts = 0;
      mon_en = 1;
      push_line(32'h6000_0000, 0);
      set_en(1);
      wait_bursts(2, "s6b");
      set_en(0);
      wait_done("s6");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
